eedc_decode: RTL and testbench

Single-error-correcting Hamming(11,7) decoder for the EEDC datapath. Takes an 11-bit codeword from the encoder/channel side and computes a 4-bit syndrome. Corrects any single-bit error and delivers the 7 recovered data bits on a registered output one clock later. Sits directly downstream of the matching EEDC encoder.

---
 rtl/eedc_pkg.sv | 31 +++
 rtl/eedc_syndrome.sv | 17 +
 rtl/eedc_decode.sv | 61 ++++++
 tb/tb_eedc_decode.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/eedc_pkg.sv
// Shared constants for the EEDC Hamming(11,7) datapath.
// Codeword bit i holds Hamming position i+1 (LSB = position 1).
package eedc_pkg;

  localparam int unsigned CW_W   = 11;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned SYN_W  = 4;

  // Parity-coverage masks: bit i set when position i+1 feeds that syndrome bit
  localparam logic [CW_W-1:0] MASK_S1 = 11'h555;  // positions 1,3,5,7,9,11
  localparam logic [CW_W-1:0] MASK_S2 = 11'h666;  // positions 2,3,6,7,10,11
  localparam logic [CW_W-1:0] MASK_S4 = 11'h078;  // positions 4,5,6,7
  localparam logic [CW_W-1:0] MASK_S8 = 11'h780;  // positions 8,9,10,11

  // Hamming position carrying data bit k
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11};

  // Largest syndrome that names a real codeword position
  localparam logic [SYN_W-1:0] SYN_MAX_VALID = 4'd11;

  // Pull the data bits out of a codeword
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      d[k] = cw[DATA_POS[k] - 1];
    end
    return d;
  endfunction

endpackage

// File: rtl/eedc_syndrome.sv
// Combinational Hamming(11,7) syndrome generator, output {s8,s4,s2,s1}.
module eedc_syndrome
  import eedc_pkg::*;
(
  input  logic [CW_W-1:0]  codeword,
  output logic [SYN_W-1:0] syndrome
);

  // Even-parity check over each coverage mask
  always_comb begin
    syndrome = {^(codeword & MASK_S8),
                ^(codeword & MASK_S4),
                ^(codeword & MASK_S2),
                ^(codeword & MASK_S1)};
  end

endmodule

// File: rtl/eedc_decode.sv
// Hamming(11,7) single-error-correcting decoder with registered output.
// Optional status outputs (err_detected, err_uncorrectable, syndrome)
// are built only when EEDC_STATUS_EN is defined.
module eedc_decode
  import eedc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   encoded_input,
  output logic [DATA_W-1:0] decoded_output
`ifdef EEDC_STATUS_EN
  ,
  output logic              err_detected,
  output logic              err_uncorrectable,
  output logic [SYN_W-1:0]  syndrome
`endif
);

  logic [SYN_W-1:0] syn;
  logic [CW_W-1:0]  corrected;

  eedc_syndrome u_syndrome (
    .codeword (encoded_input),
    .syndrome (syn)
  );

  // Flip the position the syndrome names; 0 and 12..15 match no position
  always_comb begin
    corrected = encoded_input;
    for (int unsigned i = 0; i < CW_W; i++) begin
      if (SYN_W'(i + 1) == syn) begin
        corrected[i] = ~encoded_input[i];
      end
    end
  end

  // Register the corrected data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_output <= '0;
    end else begin
      decoded_output <= extract_data(corrected);
    end
  end

`ifdef EEDC_STATUS_EN
  // Register the error status alongside the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_detected      <= 1'b0;
      err_uncorrectable <= 1'b0;
      syndrome          <= '0;
    end else begin
      err_detected      <= (syn != '0);
      err_uncorrectable <= (syn > SYN_MAX_VALID);
      syndrome          <= syn;
    end
  end
`endif

endmodule

// File: tb/tb_eedc_decode.sv
// Self-checking bench for eedc_decode: directed cases plus random codewords
// checked against a positional Hamming model.
module tb_eedc_decode;

  logic        clk;
  logic        rst;
  logic [10:0] encoded_input;
  logic [6:0]  decoded_output;
`ifdef EEDC_STATUS_EN
  logic        err_detected;
  logic        err_uncorrectable;
  logic [3:0]  syndrome;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  eedc_decode dut (
    .clk            (clk),
    .rst            (rst),
    .encoded_input  (encoded_input),
    .decoded_output (decoded_output)
`ifdef EEDC_STATUS_EN
    ,
    .err_detected      (err_detected),
    .err_uncorrectable (err_uncorrectable),
    .syndrome          (syndrome)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Syndrome = XOR of the position numbers of all set bits
  function automatic logic [3:0] ref_syn(input logic [10:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int p = 1; p <= 11; p++) begin
      if (cw[p-1]) s = s ^ 4'(p);
    end
    return s;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 8);
  endfunction

  function automatic logic [6:0] ref_decode(input logic [10:0] cw);
    logic [3:0]  s;
    logic [10:0] fixed;
    logic [6:0]  d;
    int          k;
    s = ref_syn(cw);
    fixed = cw;
    if (s >= 4'd1 && s <= 4'd11) fixed[s-1] = ~fixed[s-1];
    d = 7'd0;
    k = 0;
    for (int p = 1; p <= 11; p++) begin
      if (!is_pow2(p)) begin
        d[k] = fixed[p-1];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [10:0] ref_encode(input logic [6:0] d);
    logic [10:0] cw;
    logic [3:0]  s;
    int          k;
    cw = 11'd0;
    k = 0;
    for (int p = 1; p <= 11; p++) begin
      if (!is_pow2(p)) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    s = ref_syn(cw);
    for (int b = 0; b < 4; b++) cw[(1 << b) - 1] = s[b];
    return cw;
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [10:0] cw);
`ifdef EEDC_STATUS_EN
    logic [3:0] s;
    s = ref_syn(cw);
    check({tag, ".syn"}, {7'd0, syndrome}, {7'd0, s});
    check({tag, ".det"}, {10'd0, err_detected}, {10'd0, (s != 4'd0)});
    check({tag, ".unc"}, {10'd0, err_uncorrectable}, {10'd0, (s >= 4'd12)});
`else
    if (tag.len() == 0 && cw === 11'bx) $display("unused");
`endif
  endtask

  // Drive between edges, sample 1 time unit after the capturing edge
  task automatic apply(input logic [10:0] cw);
    @(negedge clk);
    encoded_input = cw;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input string tag, input logic [10:0] cw, input logic [6:0] exp);
    apply(cw);
    check(tag, {4'd0, decoded_output}, {4'd0, exp});
    check({tag, ".model"}, {4'd0, decoded_output}, {4'd0, ref_decode(cw)});
    check_status(tag, cw);
  endtask

  initial begin
    logic [10:0] cw;
    logic [6:0]  held;
    int          mode, p1, p2;

    rst = 1'b0;
    encoded_input = 11'h7FF;
    #1 rst = 1'b1;
    #1;
    check("reset_async", {4'd0, decoded_output}, 11'd0);
    check_status("reset_status", 11'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {4'd0, decoded_output}, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    apply_check("clean_000", 11'h000, 7'h00);
    apply_check("clean_007", 11'h007, 7'h01);
    apply_check("clean_7ff", 11'h7FF, 7'h7F);
    apply_check("par_err_006", 11'h006, 7'h01);
    apply_check("dat_err_3ff", 11'h3FF, 7'h7F);
    apply_check("uncorr_777", 11'h777, 7'h7F);

    // Input change between edges must not reach the output
    held = decoded_output;
    #2 encoded_input = 11'h000;
    #1;
    check("no_midcycle_change", {4'd0, decoded_output}, {4'd0, held});

    apply_check("b2b_0", 11'h7FF, 7'h7F);
    apply_check("b2b_1", 11'h3FF, 7'h7F);
    apply_check("b2b_2", 11'h000, 7'h00);

    // Mid-stream async reset clears immediately
    apply_check("pre_reset", 11'h7FF, 7'h7F);
    #2 rst = 1'b1;
    #1;
    check("midstream_reset", {4'd0, decoded_output}, 11'd0);
    check_status("midstream_reset_status", 11'd0);
    @(posedge clk);
    #1;
    check("midstream_reset_held", {4'd0, decoded_output}, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_check("post_reset", 11'h007, 7'h01);

    // Random clean, single-error, double-error and arbitrary words
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 3);
      cw = ref_encode(7'($urandom));
      if (mode == 1) begin
        p1 = $urandom_range(0, 10);
        cw[p1] = ~cw[p1];
      end else if (mode == 2) begin
        p1 = $urandom_range(0, 10);
        p2 = (p1 + $urandom_range(1, 10)) % 11;
        cw[p1] = ~cw[p1];
        cw[p2] = ~cw[p2];
      end else if (mode == 3) begin
        cw = 11'($urandom);
      end
      apply(cw);
      check($sformatf("rand%0d_%0h", n, cw), {4'd0, decoded_output}, {4'd0, ref_decode(cw)});
      check_status("rand", cw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
